carry_select_subtractor_16bit_pipe: RTL

Pipelined 16-bit subtractor computing diff = a - b - bin.
- Built from 4-bit carry-select blocks: the adder datapath with b inverted and carry-in = ~bin.
- Two pipeline stages with a valid/ready handshake on both sides.
- Sits beside the 16-bit carry-select adder in the arithmetic library, for datapaths needing registered subtraction with borrow and overflow flags.

---
 rtl/carry_select_subtractor_16bit_pipe.sv | 125 ++++++++++++
 1 files changed

// File: rtl/carry_select_subtractor_16bit_pipe.sv
// Two-stage pipelined subtractor diff = a - b - bin built from carry-select blocks.
// The low half resolves in stage 1; the high half resolves in stage 2 from the registered carry.
module carry_select_subtractor_16bit_pipe #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4,
    parameter int SPLIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int HI_W = WIDTH - SPLIT;
    localparam int LO_N = SPLIT / BLOCK;
    localparam int HI_N = HI_W / BLOCK;

    logic             s1_valid;
    logic [SPLIT-1:0] s1_lo;
    logic             s1_c;
    logic [HI_W-1:0]  s1_a_hi;
    logic [HI_W-1:0]  s1_nb_hi;
    logic             s1_a_msb;
    logic             s1_b_msb;

    logic             s2_adv;
    logic [SPLIT-1:0] nb_lo;
    logic [SPLIT-1:0] lo_sum;
    logic             lo_cout;
    logic [HI_W-1:0]  hi_sum;
    logic             hi_cout;
    logic             ovf_next;

    logic [BLOCK:0] lo_s0 [LO_N];
    logic [BLOCK:0] lo_s1 [LO_N];
    logic [BLOCK:0] hi_s0 [HI_N];
    logic [BLOCK:0] hi_s1 [HI_N];

    assign s2_adv   = ~out_valid | out_ready;
    assign in_ready = ~s1_valid | s2_adv;
    assign nb_lo    = ~b[SPLIT-1:0];

    // Both carry-in candidates per block are formed independently of the incoming carry.
    for (genvar k = 0; k < LO_N; k++) begin : g_lo
        assign lo_s0[k] = {1'b0, a[k*BLOCK +: BLOCK]} + {1'b0, nb_lo[k*BLOCK +: BLOCK]};
        assign lo_s1[k] = {1'b0, a[k*BLOCK +: BLOCK]} + {1'b0, nb_lo[k*BLOCK +: BLOCK]}
                          + {{BLOCK{1'b0}}, 1'b1};
    end

    for (genvar k = 0; k < HI_N; k++) begin : g_hi
        assign hi_s0[k] = {1'b0, s1_a_hi[k*BLOCK +: BLOCK]} + {1'b0, s1_nb_hi[k*BLOCK +: BLOCK]};
        assign hi_s1[k] = {1'b0, s1_a_hi[k*BLOCK +: BLOCK]} + {1'b0, s1_nb_hi[k*BLOCK +: BLOCK]}
                          + {{BLOCK{1'b0}}, 1'b1};
    end

    always_comb begin
        logic c;
        c      = ~bin;
        lo_sum = '0;
        for (int k = 0; k < LO_N; k++) begin
            lo_sum[k*BLOCK +: BLOCK] = c ? lo_s1[k][BLOCK-1:0] : lo_s0[k][BLOCK-1:0];
            c = c ? lo_s1[k][BLOCK] : lo_s0[k][BLOCK];
        end
        lo_cout = c;
    end

    always_comb begin
        logic c;
        c      = s1_c;
        hi_sum = '0;
        for (int k = 0; k < HI_N; k++) begin
            hi_sum[k*BLOCK +: BLOCK] = c ? hi_s1[k][BLOCK-1:0] : hi_s0[k][BLOCK-1:0];
            c = c ? hi_s1[k][BLOCK] : hi_s0[k][BLOCK];
        end
        hi_cout = c;
    end

    assign ovf_next = (s1_a_msb != s1_b_msb) && (hi_sum[HI_W-1] != s1_a_msb);

    // Data registers only move with valid data so outputs stay quiet across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_lo     <= '0;
            s1_c      <= 1'b0;
            s1_a_hi   <= '0;
            s1_nb_hi  <= '0;
            s1_a_msb  <= 1'b0;
            s1_b_msb  <= 1'b0;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_lo    <= lo_sum;
                    s1_c     <= lo_cout;
                    s1_a_hi  <= a[WIDTH-1:SPLIT];
                    s1_nb_hi <= ~b[WIDTH-1:SPLIT];
                    s1_a_msb <= a[WIDTH-1];
                    s1_b_msb <= b[WIDTH-1];
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    diff <= {hi_sum, s1_lo};
                    bout <= ~hi_cout;
                    ovf  <= ovf_next;
                end
            end
        end
    end

endmodule
